// File: rtl/cdb_arbiter.sv
// cdb_arbiter: merges ALU and LSB result streams onto a single registered
// common data bus. Each source is buffered in a 2-entry FIFO; when both have
// a result waiting, the source that did not win the previous grant goes next.
//
// Handshake: a source offer is accepted on a rising edge exactly when its
// *_valid and *_ready are both high at that edge. *_ready depends only on the
// registered FIFO count plus rdy/rollback, so a full FIFO refuses an offer
// even on the edge where it pops. The CDB side has no backpressure:
// cdb_valid is a one-cycle pulse per broadcast result, except that it is held
// together with every other register while rdy is low.
module cdb_arbiter #(
  parameter int ROB_ID_W = 4,
  parameter int DATA_W   = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                rollback,
  // ALU result offer
  input  logic                alu_valid,
  input  logic [ROB_ID_W-1:0] alu_alias,
  input  logic [DATA_W-1:0]   alu_result,
  input  logic                alu_jump_res,
  input  logic [DATA_W-1:0]   alu_jump_pc,
  output logic                alu_ready,
  // LSB result offer
  input  logic                lsb_valid,
  input  logic [ROB_ID_W-1:0] lsb_alias,
  input  logic [DATA_W-1:0]   lsb_result,
  output logic                lsb_ready,
  // Common data bus broadcast
  output logic                cdb_valid,
  output logic                cdb_src,
  output logic [ROB_ID_W-1:0] cdb_alias,
  output logic [DATA_W-1:0]   cdb_result,
  output logic                cdb_jump_res,
  output logic [DATA_W-1:0]   cdb_jump_pc
);

  localparam logic SRC_ALU = 1'b0;
  localparam logic SRC_LSB = 1'b1;

  // ---------------------------------------------------------------------------
  // ALU FIFO state
  // ---------------------------------------------------------------------------
  logic [1:0]                 alu_count_q,   alu_count_d;
  logic                       alu_rd_ptr_q,  alu_rd_ptr_d;
  logic                       alu_wr_ptr_q,  alu_wr_ptr_d;
  logic [1:0][ROB_ID_W-1:0]   alu_id_mem_q,  alu_id_mem_d;
  logic [1:0][DATA_W-1:0]     alu_res_mem_q, alu_res_mem_d;
  logic [1:0]                 alu_jr_mem_q,  alu_jr_mem_d;
  logic [1:0][DATA_W-1:0]     alu_pc_mem_q,  alu_pc_mem_d;

  // ---------------------------------------------------------------------------
  // LSB FIFO state
  // ---------------------------------------------------------------------------
  logic [1:0]                 lsb_count_q,   lsb_count_d;
  logic                       lsb_rd_ptr_q,  lsb_rd_ptr_d;
  logic                       lsb_wr_ptr_q,  lsb_wr_ptr_d;
  logic [1:0][ROB_ID_W-1:0]   lsb_id_mem_q,  lsb_id_mem_d;
  logic [1:0][DATA_W-1:0]     lsb_res_mem_q, lsb_res_mem_d;

  // ---------------------------------------------------------------------------
  // Arbitration and broadcast state
  // ---------------------------------------------------------------------------
  logic                       last_grant_q,  last_grant_d;
  logic                       cdb_valid_q,   cdb_valid_d;
  logic                       cdb_src_q,     cdb_src_d;
  logic [ROB_ID_W-1:0]        cdb_alias_q,   cdb_alias_d;
  logic [DATA_W-1:0]          cdb_result_q,  cdb_result_d;
  logic                       cdb_jump_res_q, cdb_jump_res_d;
  logic [DATA_W-1:0]          cdb_jump_pc_q, cdb_jump_pc_d;

  // ---------------------------------------------------------------------------
  // Combinational control
  // ---------------------------------------------------------------------------
  logic run;
  logic alu_nonempty;
  logic lsb_nonempty;
  logic alu_push;
  logic lsb_push;
  logic grant_any;
  logic grant_src;
  logic alu_pop;
  logic lsb_pop;

  // Readiness, grant selection and push/pop strobes from registered counts.
  always_comb begin
    run          = rdy && !rollback;
    alu_nonempty = (alu_count_q != 2'd0);
    lsb_nonempty = (lsb_count_q != 2'd0);

    // No same-cycle pop credit: a full FIFO stays not-ready.
    alu_ready = run && (alu_count_q < 2'd2);
    lsb_ready = run && (lsb_count_q < 2'd2);

    alu_push = alu_valid && alu_ready;
    lsb_push = lsb_valid && lsb_ready;

    // Both waiting: alternate away from the previous winner.
    grant_any = run && (alu_nonempty || lsb_nonempty);
    if (alu_nonempty && lsb_nonempty) begin
      grant_src = ~last_grant_q;
    end else if (lsb_nonempty) begin
      grant_src = SRC_LSB;
    end else begin
      grant_src = SRC_ALU;
    end

    alu_pop = grant_any && (grant_src == SRC_ALU);
    lsb_pop = grant_any && (grant_src == SRC_LSB);
  end

  // Next-state for both FIFOs: flush on rollback, hold when paused.
  always_comb begin
    alu_count_d   = alu_count_q;
    alu_rd_ptr_d  = alu_rd_ptr_q;
    alu_wr_ptr_d  = alu_wr_ptr_q;
    alu_id_mem_d  = alu_id_mem_q;
    alu_res_mem_d = alu_res_mem_q;
    alu_jr_mem_d  = alu_jr_mem_q;
    alu_pc_mem_d  = alu_pc_mem_q;
    lsb_count_d   = lsb_count_q;
    lsb_rd_ptr_d  = lsb_rd_ptr_q;
    lsb_wr_ptr_d  = lsb_wr_ptr_q;
    lsb_id_mem_d  = lsb_id_mem_q;
    lsb_res_mem_d = lsb_res_mem_q;

    if (rollback) begin
      alu_count_d  = 2'd0;
      alu_rd_ptr_d = 1'b0;
      alu_wr_ptr_d = 1'b0;
      lsb_count_d  = 2'd0;
      lsb_rd_ptr_d = 1'b0;
      lsb_wr_ptr_d = 1'b0;
    end else if (rdy) begin
      // Push and pop on the same edge cancel in the count; both pointers move.
      alu_count_d = alu_count_q + {1'b0, alu_push} - {1'b0, alu_pop};
      lsb_count_d = lsb_count_q + {1'b0, lsb_push} - {1'b0, lsb_pop};

      if (alu_push) begin
        alu_id_mem_d[alu_wr_ptr_q]  = alu_alias;
        alu_res_mem_d[alu_wr_ptr_q] = alu_result;
        alu_jr_mem_d[alu_wr_ptr_q]  = alu_jump_res;
        alu_pc_mem_d[alu_wr_ptr_q]  = alu_jump_pc;
        alu_wr_ptr_d                = alu_wr_ptr_q + 1'b1;
      end
      if (alu_pop) begin
        alu_rd_ptr_d = alu_rd_ptr_q + 1'b1;
      end

      if (lsb_push) begin
        lsb_id_mem_d[lsb_wr_ptr_q]  = lsb_alias;
        lsb_res_mem_d[lsb_wr_ptr_q] = lsb_result;
        lsb_wr_ptr_d                = lsb_wr_ptr_q + 1'b1;
      end
      if (lsb_pop) begin
        lsb_rd_ptr_d = lsb_rd_ptr_q + 1'b1;
      end
    end
  end

  // Next-state for the broadcast register and the fairness bit.
  always_comb begin
    last_grant_d   = last_grant_q;
    cdb_valid_d    = cdb_valid_q;
    cdb_src_d      = cdb_src_q;
    cdb_alias_d    = cdb_alias_q;
    cdb_result_d   = cdb_result_q;
    cdb_jump_res_d = cdb_jump_res_q;
    cdb_jump_pc_d  = cdb_jump_pc_q;

    if (rollback) begin
      // Payload fields keep their old values; only the strobe drops.
      cdb_valid_d  = 1'b0;
      last_grant_d = SRC_LSB;
    end else if (rdy) begin
      cdb_valid_d = grant_any;
      if (alu_pop) begin
        last_grant_d   = SRC_ALU;
        cdb_src_d      = SRC_ALU;
        cdb_alias_d    = alu_id_mem_q[alu_rd_ptr_q];
        cdb_result_d   = alu_res_mem_q[alu_rd_ptr_q];
        cdb_jump_res_d = alu_jr_mem_q[alu_rd_ptr_q];
        cdb_jump_pc_d  = alu_pc_mem_q[alu_rd_ptr_q];
      end else if (lsb_pop) begin
        last_grant_d   = SRC_LSB;
        cdb_src_d      = SRC_LSB;
        cdb_alias_d    = lsb_id_mem_q[lsb_rd_ptr_q];
        cdb_result_d   = lsb_res_mem_q[lsb_rd_ptr_q];
        cdb_jump_res_d = 1'b0;
        cdb_jump_pc_d  = '0;
      end
    end
  end

  // State registers with synchronous reset; reset discards everything buffered.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_count_q    <= 2'd0;
      alu_rd_ptr_q   <= 1'b0;
      alu_wr_ptr_q   <= 1'b0;
      alu_id_mem_q   <= '0;
      alu_res_mem_q  <= '0;
      alu_jr_mem_q   <= '0;
      alu_pc_mem_q   <= '0;
      lsb_count_q    <= 2'd0;
      lsb_rd_ptr_q   <= 1'b0;
      lsb_wr_ptr_q   <= 1'b0;
      lsb_id_mem_q   <= '0;
      lsb_res_mem_q  <= '0;
      last_grant_q   <= SRC_LSB;
      cdb_valid_q    <= 1'b0;
      cdb_src_q      <= 1'b0;
      cdb_alias_q    <= '0;
      cdb_result_q   <= '0;
      cdb_jump_res_q <= 1'b0;
      cdb_jump_pc_q  <= '0;
    end else begin
      alu_count_q    <= alu_count_d;
      alu_rd_ptr_q   <= alu_rd_ptr_d;
      alu_wr_ptr_q   <= alu_wr_ptr_d;
      alu_id_mem_q   <= alu_id_mem_d;
      alu_res_mem_q  <= alu_res_mem_d;
      alu_jr_mem_q   <= alu_jr_mem_d;
      alu_pc_mem_q   <= alu_pc_mem_d;
      lsb_count_q    <= lsb_count_d;
      lsb_rd_ptr_q   <= lsb_rd_ptr_d;
      lsb_wr_ptr_q   <= lsb_wr_ptr_d;
      lsb_id_mem_q   <= lsb_id_mem_d;
      lsb_res_mem_q  <= lsb_res_mem_d;
      last_grant_q   <= last_grant_d;
      cdb_valid_q    <= cdb_valid_d;
      cdb_src_q      <= cdb_src_d;
      cdb_alias_q    <= cdb_alias_d;
      cdb_result_q   <= cdb_result_d;
      cdb_jump_res_q <= cdb_jump_res_d;
      cdb_jump_pc_q  <= cdb_jump_pc_d;
    end
  end

  // Registered broadcast outputs.
  always_comb begin
    cdb_valid    = cdb_valid_q;
    cdb_src      = cdb_src_q;
    cdb_alias    = cdb_alias_q;
    cdb_result   = cdb_result_q;
    cdb_jump_res = cdb_jump_res_q;
    cdb_jump_pc  = cdb_jump_pc_q;
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed scenarios plus a randomized run, all checked
// against a queue-based reference model of the arbiter.
module tb_cdb_arbiter;
  localparam int RW = 4;
  localparam int DW = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, rdy, rollback;
  logic          alu_valid, alu_jump_res, alu_ready;
  logic [RW-1:0] alu_alias;
  logic [DW-1:0] alu_result, alu_jump_pc;
  logic          lsb_valid, lsb_ready;
  logic [RW-1:0] lsb_alias;
  logic [DW-1:0] lsb_result;
  logic          cdb_valid, cdb_src, cdb_jump_res;
  logic [RW-1:0] cdb_alias;
  logic [DW-1:0] cdb_result, cdb_jump_pc;

  cdb_arbiter #(.ROB_ID_W(RW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .alu_valid(alu_valid), .alu_alias(alu_alias), .alu_result(alu_result),
    .alu_jump_res(alu_jump_res), .alu_jump_pc(alu_jump_pc), .alu_ready(alu_ready),
    .lsb_valid(lsb_valid), .lsb_alias(lsb_alias), .lsb_result(lsb_result),
    .lsb_ready(lsb_ready),
    .cdb_valid(cdb_valid), .cdb_src(cdb_src), .cdb_alias(cdb_alias),
    .cdb_result(cdb_result), .cdb_jump_res(cdb_jump_res), .cdb_jump_pc(cdb_jump_pc)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [RW-1:0] id;
    logic [DW-1:0] res;
    logic          jr;
    logic [DW-1:0] jpc;
  } ent_t;

  ent_t          m_alu_q[$];
  ent_t          m_lsb_q[$];
  logic          m_last;
  logic          m_valid, m_src, m_jr;
  logic [RW-1:0] m_id;
  logic [DW-1:0] m_res, m_jpc;

  function automatic logic exp_ready(int n);
    return rdy && !rollback && (n < 2);
  endfunction

  // Advance the model by one edge using the current inputs, then step the clock.
  task automatic tick();
    logic a_acc, l_acc;
    ent_t g;
    a_acc = alu_valid && exp_ready(m_alu_q.size());
    l_acc = lsb_valid && exp_ready(m_lsb_q.size());
    if (rst) begin
      m_alu_q.delete(); m_lsb_q.delete();
      m_last = 1'b1; m_valid = 1'b0; m_src = 1'b0;
      m_id = '0; m_res = '0; m_jr = 1'b0; m_jpc = '0;
    end else if (rollback) begin
      m_alu_q.delete(); m_lsb_q.delete();
      m_valid = 1'b0; m_last = 1'b1;
    end else if (rdy) begin
      if (m_alu_q.size() > 0 && (m_lsb_q.size() == 0 || m_last == 1'b1)) begin
        g = m_alu_q.pop_front();
        m_valid = 1'b1; m_src = 1'b0; m_id = g.id; m_res = g.res;
        m_jr = g.jr; m_jpc = g.jpc; m_last = 1'b0;
      end else if (m_lsb_q.size() > 0) begin
        g = m_lsb_q.pop_front();
        m_valid = 1'b1; m_src = 1'b1; m_id = g.id; m_res = g.res;
        m_jr = 1'b0; m_jpc = '0; m_last = 1'b1;
      end else begin
        m_valid = 1'b0;
      end
      if (a_acc) m_alu_q.push_back('{alu_alias, alu_result, alu_jump_res, alu_jump_pc});
      if (l_acc) m_lsb_q.push_back('{lsb_alias, lsb_result, 1'b0, '0});
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_alu(input logic v, input logic [RW-1:0] id,
                           input logic [DW-1:0] res, input logic jr,
                           input logic [DW-1:0] jpc);
    alu_valid = v; alu_alias = id; alu_result = res;
    alu_jump_res = jr; alu_jump_pc = jpc;
  endtask

  task automatic drive_lsb(input logic v, input logic [RW-1:0] id,
                           input logic [DW-1:0] res);
    lsb_valid = v; lsb_alias = id; lsb_result = res;
  endtask

  task automatic idle();
    drive_alu(1'b0, '0, '0, 1'b0, '0);
    drive_lsb(1'b0, '0, '0);
  endtask

  task automatic do_reset();
    idle();
    rdy = 1'b1; rollback = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", cdb_valid); end
    checks++; if (cdb_src !== 1'b0) begin errors++; $display("FAIL reset_src got %0b want 0", cdb_src); end
    checks++; if (cdb_alias !== '0) begin errors++; $display("FAIL reset_alias got %0d want 0", cdb_alias); end
    checks++; if (cdb_result !== '0) begin errors++; $display("FAIL reset_result got %0h want 0", cdb_result); end
    checks++; if (cdb_jump_res !== 1'b0) begin errors++; $display("FAIL reset_jres got %0b want 0", cdb_jump_res); end
    checks++; if (cdb_jump_pc !== '0) begin errors++; $display("FAIL reset_jpc got %0h want 0", cdb_jump_pc); end
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL reset_alu_ready got %0b want 1", alu_ready); end
    checks++; if (lsb_ready !== 1'b1) begin errors++; $display("FAIL reset_lsb_ready got %0b want 1", lsb_ready); end
    // Reset while paused must still discard buffered results.
    drive_alu(1'b1, 4'd9, 32'h99, 1'b0, '0);
    tick();
    idle(); rdy = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0; rdy = 1'b1;
    tick();
    checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL reset_discard got valid %0b want 0", cdb_valid); end
  endtask

  task automatic test_single_alu();
    do_reset();
    drive_alu(1'b1, 4'd3, 32'h2A, 1'b1, 32'h100);
    tick();
    idle();
    checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL single_latency got valid %0b want 0", cdb_valid); end
    tick();
    checks++; if (cdb_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %0b want 1", cdb_valid); end
    checks++; if (cdb_src !== 1'b0) begin errors++; $display("FAIL single_src got %0b want 0", cdb_src); end
    checks++; if (cdb_alias !== 4'd3) begin errors++; $display("FAIL single_alias got %0d want 3", cdb_alias); end
    checks++; if (cdb_result !== 32'h2A) begin errors++; $display("FAIL single_result got %0h want 2a", cdb_result); end
    checks++; if (cdb_jump_res !== 1'b1) begin errors++; $display("FAIL single_jres got %0b want 1", cdb_jump_res); end
    checks++; if (cdb_jump_pc !== 32'h100) begin errors++; $display("FAIL single_jpc got %0h want 100", cdb_jump_pc); end
    tick();
    checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL single_pulse got %0b want 0", cdb_valid); end
    checks++; if (cdb_alias !== 4'd3) begin errors++; $display("FAIL single_hold got alias %0d want 3", cdb_alias); end
  endtask

  task automatic test_contention();
    logic [RW-1:0] exp_ids [6];
    logic [RW-1:0] got_id[$];
    logic          got_src[$];
    int a_i, l_i;
    logic a_acc, l_acc;
    exp_ids = '{4'd1, 4'd4, 4'd2, 4'd5, 4'd3, 4'd6};
    a_i = 0; l_i = 0;
    do_reset();
    for (int c = 0; c < 20 && got_id.size() < 6; c++) begin
      drive_alu(a_i < 3, RW'(a_i + 1), 32'(a_i + 100), 1'b0, '0);
      drive_lsb(l_i < 3, RW'(l_i + 4), 32'(l_i + 200));
      #1;
      a_acc = alu_valid && alu_ready;
      l_acc = lsb_valid && lsb_ready;
      tick();
      if (a_acc) a_i++;
      if (l_acc) l_i++;
      if (cdb_valid) begin got_id.push_back(cdb_alias); got_src.push_back(cdb_src); end
    end
    idle();
    checks++;
    if (got_id.size() != 6) begin
      errors++; $display("FAIL contention_count got %0d want 6", got_id.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++; if (got_id[i] !== exp_ids[i]) begin errors++; $display("FAIL contention_alias[%0d] got %0d want %0d", i, got_id[i], exp_ids[i]); end
        checks++; if (got_src[i] !== 1'(i % 2)) begin errors++; $display("FAIL contention_src[%0d] got %0b want %0d", i, got_src[i], i % 2); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [RW-1:0] lsb_got[$];
    int a_i, l_i;
    logic a_acc, l_acc, saw_full;
    a_i = 0; l_i = 0; saw_full = 1'b0;
    do_reset();
    for (int c = 0; c < 25; c++) begin
      drive_alu(a_i < 4, RW'(a_i + 1), 32'(a_i), 1'b0, '0);
      drive_lsb(l_i < 3, RW'(l_i + 7), 32'(l_i + 70));
      #1;
      if (lsb_valid && !lsb_ready) saw_full = 1'b1;
      a_acc = alu_valid && alu_ready;
      l_acc = lsb_valid && lsb_ready;
      tick();
      if (a_acc) a_i++;
      if (l_acc) l_i++;
      if (cdb_valid && cdb_src) lsb_got.push_back(cdb_alias);
    end
    idle();
    checks++; if (saw_full !== 1'b1) begin errors++; $display("FAIL bp_lsb_ready_low got %0b want 1", saw_full); end
    checks++;
    if (lsb_got.size() != 3) begin
      errors++; $display("FAIL bp_lsb_count got %0d want 3", lsb_got.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++; if (lsb_got[i] !== RW'(i + 7)) begin errors++; $display("FAIL bp_lsb_order[%0d] got %0d want %0d", i, lsb_got[i], i + 7); end
      end
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int c = 0; c < 5; c++) begin
      drive_alu(1'b1, RW'(c + 1), 32'(c), 1'b0, '0);
      drive_lsb(1'b1, RW'(c + 9), 32'(c));
      tick();
    end
    // Offers stay up during the flush edge; none may be taken.
    rollback = 1'b1;
    #1;
    checks++; if (alu_ready !== 1'b0) begin errors++; $display("FAIL flush_alu_ready got %0b want 0", alu_ready); end
    checks++; if (lsb_ready !== 1'b0) begin errors++; $display("FAIL flush_lsb_ready got %0b want 0", lsb_ready); end
    tick();
    rollback = 1'b0; idle();
    checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %0b want 0", cdb_valid); end
    #1;
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL flush_alu_ready_after got %0b want 1", alu_ready); end
    checks++; if (lsb_ready !== 1'b1) begin errors++; $display("FAIL flush_lsb_ready_after got %0b want 1", lsb_ready); end
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL flush_stale cycle %0d got valid %0b alias %0d want 0", c, cdb_valid, cdb_alias); end
    end
  endtask

  task automatic test_pause();
    do_reset();
    drive_alu(1'b1, 4'd5, 32'h55, 1'b0, '0);
    tick();
    drive_alu(1'b1, 4'd6, 32'h66, 1'b0, '0);
    tick();
    checks++; if (cdb_valid !== 1'b1 || cdb_alias !== 4'd5) begin errors++; $display("FAIL pause_setup got valid %0b alias %0d want 1/5", cdb_valid, cdb_alias); end
    rdy = 1'b0;
    drive_alu(1'b1, 4'd7, 32'h77, 1'b0, '0);
    drive_lsb(1'b1, 4'd8, 32'h88);
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (alu_ready !== 1'b0 || lsb_ready !== 1'b0) begin errors++; $display("FAIL pause_ready cycle %0d got %0b/%0b want 0/0", c, alu_ready, lsb_ready); end
      tick();
      checks++; if (cdb_valid !== 1'b1 || cdb_alias !== 4'd5 || cdb_result !== 32'h55) begin
        errors++; $display("FAIL pause_hold cycle %0d got valid %0b alias %0d want 1/5", c, cdb_valid, cdb_alias);
      end
    end
    rdy = 1'b1; idle();
    tick();
    checks++; if (cdb_valid !== 1'b1 || cdb_alias !== 4'd6) begin errors++; $display("FAIL pause_resume got valid %0b alias %0d want 1/6", cdb_valid, cdb_alias); end
    tick();
    checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL pause_no_accept got valid %0b alias %0d want 0", cdb_valid, cdb_alias); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rst      = ($urandom_range(0, 99) == 0);
      rollback = ($urandom_range(0, 29) == 0);
      rdy      = ($urandom_range(0, 4) != 0);
      drive_alu($urandom_range(0, 9) < 6, RW'($urandom), $urandom, 1'($urandom), $urandom);
      drive_lsb($urandom_range(0, 9) < 6, RW'($urandom), $urandom);
      #1;
      checks++; if (alu_ready !== exp_ready(m_alu_q.size())) begin errors++; $display("FAIL rand_alu_ready cycle %0d got %0b want %0b", c, alu_ready, exp_ready(m_alu_q.size())); end
      checks++; if (lsb_ready !== exp_ready(m_lsb_q.size())) begin errors++; $display("FAIL rand_lsb_ready cycle %0d got %0b want %0b", c, lsb_ready, exp_ready(m_lsb_q.size())); end
      tick();
      checks++;
      if (cdb_valid !== m_valid || cdb_src !== m_src || cdb_alias !== m_id ||
          cdb_result !== m_res || cdb_jump_res !== m_jr || cdb_jump_pc !== m_jpc) begin
        errors++;
        $display("FAIL rand_cdb cycle %0d got v%0b s%0b a%0d r%0h j%0b p%0h want v%0b s%0b a%0d r%0h j%0b p%0h",
                 c, cdb_valid, cdb_src, cdb_alias, cdb_result, cdb_jump_res, cdb_jump_pc,
                 m_valid, m_src, m_id, m_res, m_jr, m_jpc);
      end
    end
    rst = 1'b0; rollback = 1'b0; rdy = 1'b1; idle();
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------- sequence + report ----------------
  initial begin
    rst = 1'b1; rdy = 1'b1; rollback = 1'b0;
    idle();
    m_last = 1'b1; m_valid = 1'b0; m_src = 1'b0;
    m_id = '0; m_res = '0; m_jr = 1'b0; m_jpc = '0;
    @(posedge clk); #1;
    test_reset();
    test_single_alu();
    test_contention();
    test_backpressure();
    test_flush();
    test_pause();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 The block SHALL have parameter ROB_ID_W, default 4, meaning the ROB alias width.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning the result and PC width.
REQ-003 The block SHALL have a single clock and a synchronous, active-high reset.
REQ-004 The block SHALL have these ports: clk  in  1  clock, all state updates on the rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 rdy  in  1  global run enable; low = pause.
REQ-007 rollback  in  1  misprediction flush from the ROB.
REQ-008 alu_valid  in  1;  alu_alias  in  ROB_ID_W;  alu_result  in  DATA_W;  alu_jump_res  in  1;  alu_jump_pc  in  DATA_W.  These form the ALU result offer.
REQ-009 alu_ready  out  1  ALU offer accepted this edge when alu_valid and alu_ready are both high.
REQ-010 lsb_valid  in  1;  lsb_alias  in  ROB_ID_W;  lsb_result  in  DATA_W.  These form the LSB result offer.
REQ-011 lsb_ready  out  1  LSB offer accepted this edge when lsb_valid and lsb_ready are both high.
REQ-012 cdb_valid  out  1;  cdb_src  out  1 (0=ALU, 1=LSB);  cdb_alias  out  ROB_ID_W;  cdb_result  out  DATA_W;  cdb_jump_res  out  1;  cdb_jump_pc  out  DATA_W.  These form the single registered common-data-bus broadcast to the ROB, RS and LSB.

Function
REQ-013 Each source SHALL own a 2-entry FIFO with a 2-bit count (0..2) and 1-bit read and write pointers that wrap 1->0.
REQ-014 The ALU FIFO SHALL store alias, result, jump_res and jump_pc; the LSB FIFO SHALL store alias and result.
REQ-015 alu_ready SHALL equal rdy && !rollback && (alu_count < 2); lsb_ready SHALL be defined the same way from lsb_count.
REQ-016 ready SHALL depend only on registered count, with no same-cycle pop credit, so a full FIFO refuses input even while popping.
REQ-017 Arbitration SHALL use FIFO contents at the start of the cycle; an entry accepted at edge k SHALL appear on the CDB at edge k+1 at the earliest.
REQ-018 Grant rules: only one FIFO non-empty -> grant it; both non-empty -> grant the source != last_grant; neither -> no grant.
REQ-019 last_grant SHALL update to the granted source only on a grant edge.
REQ-020 On a grant edge, the block SHALL set cdb_valid=1, load cdb_src and the head fields, and pop that FIFO.
REQ-021 For an LSB grant, cdb_jump_res SHALL be 0 and cdb_jump_pc SHALL be 0.
REQ-022 On an edge with no grant, cdb_valid SHALL be 0 and the other cdb fields SHALL hold their previous values.
REQ-023 cdb_valid SHALL be a one-cycle pulse per result; exactly one result SHALL be broadcast per granted edge.
REQ-024 A push and a pop on the same FIFO in the same edge SHALL leave count unchanged; pointers SHALL both advance.
REQ-025 Priority SHALL be rst > rollback > !rdy > normal operation.
REQ-026 When rollback=1 at an edge, the block SHALL clear both FIFOs (counts and pointers to 0), set cdb_valid=0, set last_grant=1 (LSB), and accept nothing.
REQ-027 When rdy=0, all registers SHALL hold, including cdb_valid, and no push or pop SHALL occur.
REQ-028 Results SHALL never be dropped, duplicated or reordered within a source except by rst or rollback.

Reset
REQ-029 On rst at an edge: FIFOs empty, last_grant=1, cdb_valid=0, cdb_src=0, cdb_alias=0, cdb_result=0, cdb_jump_res=0, cdb_jump_pc=0.
REQ-030 After reset, alu_ready=1 and lsb_ready=1 while rdy=1 and rollback=0.
REQ-031 rst asserted mid-operation SHALL discard all buffered results regardless of rdy.

Verification
REQ-032 Single ALU: alu_valid with alias=3, result=0x2A, jump_res=1, jump_pc=0x100 at edge 1 -> at edge 2, cdb_valid=1, src=0, alias=3, result=0x2A, jump_res=1, jump_pc=0x100; at edge 3, cdb_valid=0.
REQ-033 Contention: both sources offer every cycle from reset, ALU aliases 1,2,3 and LSB aliases 4,5,6 -> CDB order is alias 1,4,2,5,3,6 with src alternating 0,1.
REQ-034 Backpressure: hold lsb_valid with aliases 7,8,9 while ALU wins -> lsb_ready=0 once count=2; no LSB alias is lost and LSB aliases appear in order 7,8,9.
REQ-035 Flush: fill both FIFOs, then pulse rollback -> cdb_valid=0 on the next edge, both readies=1 afterward, and no pre-flush alias is ever broadcast.
REQ-036 Pause: rdy=0 for 3 cycles while cdb_valid=1 with alias=5 -> outputs frozen, alias 5 still valid, no accepts; on resume, the next FIFO head follows.
